// File: rtl/multi_cycle_cpu_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset core:
// FSM state codes, opcode/funct values, ALU operation encoding.
package multi_cycle_cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IF      = 5'd0,
        ST_ID      = 5'd1,
        ST_EX_R    = 5'd2,
        ST_WB_R    = 5'd3,
        ST_EX_I    = 5'd4,
        ST_WB_I    = 5'd5,
        ST_MEM_ADR = 5'd6,
        ST_MEM_RD  = 5'd7,
        ST_WB_LW   = 5'd8,
        ST_MEM_WR  = 5'd9,
        ST_BR      = 5'd10,
        ST_J       = 5'd11,
        ST_JAL     = 5'd12,
        ST_JAL_WB  = 5'd13,
        ST_JR      = 5'd14
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    // R-format view of an instruction word; I/J fields are sliced from the raw word
    typedef struct packed {
        logic [5:0]        op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
    } instr_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_cpu_if.sv
// Shared memory/IO port of the core: one address, one read bus, one write bus.
interface multi_cycle_cpu_if;

    logic        MIO_ready;
    logic [31:0] Data_in;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        CPU_MIO;

    modport master (
        input  MIO_ready, Data_in,
        output mem_w, Addr_out, Data_out, CPU_MIO
    );

    modport slave (
        output MIO_ready, Data_in,
        input  mem_w, Addr_out, Data_out, CPU_MIO
    );

endinterface

// File: rtl/mcpu_alu.sv
// Combinational 32-bit ALU: add/sub wrap, signed slt, bitwise and/or/nor.
module mcpu_alu
    import multi_cycle_cpu_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y_c
);

    always_comb begin
        y_c = '0;
        unique case (op)
            ALU_ADD: y_c = a + b;
            ALU_SUB: y_c = a - b;
            ALU_AND: y_c = a & b;
            ALU_OR:  y_c = a | b;
            ALU_NOR: y_c = ~(a | b);
            ALU_SLT: y_c = {31'd0, ($signed(a) < $signed(b))};
            default: y_c = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core on one shared memory/IO port.
// Build option MIO_WAIT_EN: IF/MEM_RD/MEM_WR hold until MIO_ready is high.
module multi_cycle_cpu
    import multi_cycle_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                INT,
    output logic [XLEN-1:0]     PC_out,
    output logic [XLEN-1:0]     inst_out,
    output logic [STATE_W-1:0]  state,
    multi_cycle_cpu_if.master   bus
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] ir, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] alu_out, alu_out_d;
    logic [XLEN-1:0] mdr, mdr_d;

    logic [XLEN-1:0] addr_q, data_out_q;
    logic            mem_w_q, cpu_mio_q;

    logic [XLEN-1:0] rf [32];
    logic            rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;

    instr_t          ins;
    logic [15:0]     imm;
    logic [XLEN-1:0] imm_sx, imm_zx, br_off, jmp_tgt;
    logic            mio_go;
    logic            unused_ok;

    assign ins     = instr_t'(ir);
    assign imm     = ir[15:0];
    assign imm_sx  = sext16(imm);
    assign imm_zx  = {16'd0, imm};
    assign br_off  = {imm_sx[29:0], 2'b00};
    assign jmp_tgt = {pc[31:28], ir[25:0], 2'b00};

`ifdef MIO_WAIT_EN
    assign mio_go    = bus.MIO_ready;
    assign unused_ok = ^{INT, ins.shamt};
`else
    assign mio_go    = 1'b1;
    assign unused_ok = ^{INT, ins.shamt, bus.MIO_ready};
`endif

    mcpu_alu u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .y_c (alu_y)
    );

    // Next-state, datapath and register-file write decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        ir_d      = ir;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out;
        mdr_d     = mdr;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        alu_op    = ALU_ADD;
        alu_a     = a_q;
        alu_b     = b_q;

        unique case (state_q)
            ST_IF: begin
                if (mio_go) begin
                    ir_d    = bus.Data_in;
                    pc_d    = pc + 32'd4;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                a_d     = rf[ins.rs];
                b_d     = rf[ins.rt];
                state_d = ST_IF;
                case (ins.op)
                    OP_RTYPE: begin
                        case (ins.funct)
                            FN_ADD, FN_SUB, FN_AND,
                            FN_OR, FN_SLT, FN_NOR: state_d = ST_EX_R;
                            FN_JR, FN_JALR:        state_d = ST_JR;
                            default:               state_d = ST_IF;
                        endcase
                    end
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_LUI:   state_d = ST_EX_I;
                    OP_LW, OP_SW:      state_d = ST_MEM_ADR;
                    OP_BEQ, OP_BNE:    state_d = ST_BR;
                    OP_J:              state_d = ST_J;
                    OP_JAL:            state_d = ST_JAL;
                    default:           state_d = ST_IF;
                endcase
            end
            ST_EX_R: begin
                alu_op    = funct_to_alu(ins.funct);
                alu_out_d = alu_y;
                state_d   = ST_WB_R;
            end
            ST_WB_R: begin
                rf_we    = 1'b1;
                rf_waddr = ins.rd;
                rf_wdata = alu_out;
                state_d  = ST_IF;
            end
            ST_EX_I: begin
                case (ins.op)
                    OP_SLTI: begin alu_op = ALU_SLT; alu_b = imm_sx; end
                    OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zx; end
                    OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zx; end
                    OP_LUI:  begin alu_a = '0; alu_b = {imm, 16'd0}; end
                    default: alu_b = imm_sx;
                endcase
                alu_out_d = alu_y;
                state_d   = ST_WB_I;
            end
            ST_WB_I: begin
                rf_we    = 1'b1;
                rf_waddr = ins.rt;
                rf_wdata = alu_out;
                state_d  = ST_IF;
            end
            ST_MEM_ADR: begin
                alu_b     = imm_sx;
                alu_out_d = alu_y;
                state_d   = (ins.op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (mio_go) begin
                    mdr_d   = bus.Data_in;
                    state_d = ST_WB_LW;
                end
            end
            ST_WB_LW: begin
                rf_we    = 1'b1;
                rf_waddr = ins.rt;
                rf_wdata = mdr;
                state_d  = ST_IF;
            end
            ST_MEM_WR: begin
                if (mio_go) state_d = ST_IF;
            end
            ST_BR: begin
                // pc already points past the branch, so the offset is relative to fetch+4
                if ((a_q == b_q) ^ (ins.op == OP_BNE)) pc_d = pc + br_off;
                state_d = ST_IF;
            end
            ST_J: begin
                pc_d    = jmp_tgt;
                state_d = ST_IF;
            end
            ST_JAL: begin
                rf_we    = 1'b1;
                rf_waddr = REG_AW'(31);
                rf_wdata = pc;
                state_d  = ST_JAL_WB;
            end
            ST_JAL_WB: begin
                pc_d    = jmp_tgt;
                state_d = ST_IF;
            end
            ST_JR: begin
                // jalr rd==rs is safe: A latched the old rs value during ID
                pc_d = a_q;
                if (ins.funct == FN_JALR) begin
                    rf_we    = 1'b1;
                    rf_waddr = ins.rd;
                    rf_wdata = pc;
                end
                state_d = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
    end

    // State, datapath and registered bus outputs; bus outputs track the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IF;
            pc         <= RESET_PC;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            addr_q     <= RESET_PC;
            data_out_q <= '0;
            mem_w_q    <= 1'b0;
            cpu_mio_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            ir         <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_out    <= alu_out_d;
            mdr        <= mdr_d;
            addr_q     <= (state_d == ST_MEM_RD || state_d == ST_MEM_WR) ? alu_out_d : pc_d;
            data_out_q <= b_d;
            mem_w_q    <= (state_d == ST_MEM_WR);
            cpu_mio_q  <= (state_d == ST_IF || state_d == ST_MEM_RD || state_d == ST_MEM_WR);
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && (rf_waddr != '0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    assign PC_out       = pc;
    assign inst_out     = ir;
    assign state        = state_q;
    assign bus.Addr_out = addr_q;
    assign bus.Data_out = data_out_q;
    assign bus.mem_w    = mem_w_q;
    assign bus.CPU_MIO  = cpu_mio_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed-vector bench for multi_cycle_cpu; register contents are observed through sw.
module tb_multi_cycle_cpu;

    logic        clk;
    logic        reset;
    logic        INT;
    logic [31:0] PC_out;
    logic [31:0] inst_out;
    logic [4:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    multi_cycle_cpu_if bus ();

    multi_cycle_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .INT      (INT),
        .PC_out   (PC_out),
        .inst_out (inst_out),
        .state    (state),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction for a fixed cycle count and expect to be back in IF at exp_pc
    task automatic exec(input string tag, input logic [31:0] instr, input int cycles,
                        input logic [31:0] exp_pc);
        bus.Data_in = instr;
        repeat (cycles) tick();
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " pc"}, PC_out, exp_pc);
    endtask

    // sw rt,off($0): check the single write cycle and the return to IF
    task automatic store_chk(input string tag, input logic [4:0] rt, input logic [15:0] off,
                             input logic [31:0] exp, input logic [31:0] exp_pc);
        bus.Data_in = {6'h2B, 5'd0, rt, off};
        repeat (3) tick();
        check({tag, " st9"}, 32'(state), 32'd9);
        check({tag, " mem_w"}, 32'(bus.mem_w), 32'd1);
        check({tag, " addr"}, bus.Addr_out, {16'd0, off});
        check({tag, " data"}, bus.Data_out, exp);
        tick();
        check({tag, " mem_w end"}, 32'(bus.mem_w), 32'd0);
        check({tag, " pc"}, PC_out, exp_pc);
    endtask

    initial begin
        reset         = 1'b1;
        INT           = 1'b0;
        bus.MIO_ready = 1'b1;
        bus.Data_in   = 32'd0;
        #12;
        check("rst pc", PC_out, 32'd0);
        check("rst ir", inst_out, 32'd0);
        check("rst state", 32'(state), 32'd0);
        check("rst mem_w", 32'(bus.mem_w), 32'd0);
        check("rst cpu_mio", 32'(bus.CPU_MIO), 32'd1);
        check("rst addr", bus.Addr_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // j 0x14
        bus.Data_in = 32'h0800_0005;
        tick();
        check("j ir", inst_out, 32'h0800_0005);
        check("j id", 32'(state), 32'd1);
        check("j pc+4", PC_out, 32'd4);
        tick();
        check("j st", 32'(state), 32'd11);
        tick();
        check("j pc", PC_out, 32'h14);
        check("j state", 32'(state), 32'd0);
        check("j addr", bus.Addr_out, 32'h14);

        // jal 0x14 from 0x14: $31 = 0x18
        bus.Data_in = 32'h0C00_0005;
        repeat (3) tick();
        check("jal st13", 32'(state), 32'd13);
        tick();
        check("jal pc", PC_out, 32'h14);
        check("jal state", 32'(state), 32'd0);

        exec("jr ra", 32'h03E0_0008, 3, 32'h18);
        exec("jalr t1", 32'h03E0_4809, 3, 32'h18);
        exec("jr t1", 32'h0120_0008, 3, 32'h1C);

        // addi $t0,$0,-1 ; sw $t0,8($0)
        exec("addi", 32'h2008_FFFF, 4, 32'h20);
        bus.Data_in = 32'hAC08_0008;
        repeat (2) tick();
        check("sw adr cpu_mio", 32'(bus.CPU_MIO), 32'd0);
        check("sw adr mem_w", 32'(bus.mem_w), 32'd0);
        tick();
        check("sw st9", 32'(state), 32'd9);
        check("sw mem_w", 32'(bus.mem_w), 32'd1);
        check("sw addr", bus.Addr_out, 32'd8);
        check("sw data", bus.Data_out, 32'hFFFF_FFFF);
        check("sw cpu_mio", 32'(bus.CPU_MIO), 32'd1);
        tick();
        check("sw mem_w off", 32'(bus.mem_w), 32'd0);
        check("sw addr pc", bus.Addr_out, 32'h24);
        check("sw state", 32'(state), 32'd0);

        exec("lui",  32'h3C0A_1234, 4, 32'h28);
        exec("ori",  32'h354A_8765, 4, 32'h2C);
        exec("add",  32'h010A_5820, 4, 32'h30);
        exec("slt",  32'h010A_602A, 4, 32'h34);
        exec("sub",  32'h0008_6822, 4, 32'h38);
        store_chk("s t3", 5'd11, 16'h10, 32'h1234_8764, 32'h3C);
        store_chk("s t4", 5'd12, 16'h10, 32'd1, 32'h40);
        store_chk("s t5", 5'd13, 16'h10, 32'd1, 32'h44);
        exec("slti", 32'h290F_0000, 4, 32'h48);
        store_chk("s t7", 5'd15, 16'h10, 32'd1, 32'h4C);
        exec("addi r0", 32'h2000_0005, 4, 32'h50);
        store_chk("s r0", 5'd0, 16'h10, 32'd0, 32'h54);
        store_chk("s ra", 5'd31, 16'h10, 32'h18, 32'h58);
        store_chk("s t1", 5'd9, 16'h10, 32'h1C, 32'h5C);

        // lw $t6,4($0): load data arrives in MEM_RD
        bus.Data_in = 32'h8C0E_0004;
        repeat (3) tick();
        check("lw st7", 32'(state), 32'd7);
        check("lw addr", bus.Addr_out, 32'd4);
        check("lw cpu_mio", 32'(bus.CPU_MIO), 32'd1);
        check("lw mem_w", 32'(bus.mem_w), 32'd0);
        bus.Data_in = 32'hCAFE_F00D;
        tick();
        check("lw st8", 32'(state), 32'd8);
        tick();
        check("lw pc", PC_out, 32'h60);
        store_chk("s t6", 5'd14, 16'h10, 32'hCAFE_F00D, 32'h64);

        exec("beq fwd", 32'h1000_0003, 3, 32'h74);
        exec("bne nt",  32'h1400_0003, 3, 32'h78);
        exec("beq back", 32'h1000_FFFE, 3, 32'h74);
        exec("bad op",  32'hFC00_0000, 2, 32'h78);

        // Reset in the middle of a store: no write strobe, GPRs cleared
        bus.Data_in = 32'hAC08_0008;
        repeat (2) tick();
        check("mid st6", 32'(state), 32'd6);
        reset = 1'b1;
        #1;
        check("mid rst state", 32'(state), 32'd0);
        check("mid rst pc", PC_out, 32'd0);
        check("mid rst mem_w", 32'(bus.mem_w), 32'd0);
        check("mid rst cpu_mio", 32'(bus.CPU_MIO), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        store_chk("s t0 clr", 5'd8, 16'h10, 32'd0, 32'h4);

        // Memory-ready handshake on a store
        exec("addi2", 32'h2008_FFFF, 4, 32'h8);
        bus.Data_in = 32'hAC08_0008;
        repeat (3) tick();
        check("wait st9", 32'(state), 32'd9);
        bus.MIO_ready = 1'b0;
        tick();
`ifdef MIO_WAIT_EN
        check("wait hold", 32'(state), 32'd9);
        check("wait mem_w", 32'(bus.mem_w), 32'd1);
        check("wait addr", bus.Addr_out, 32'd8);
        tick();
        check("wait hold2", 32'(state), 32'd9);
        check("wait pc", PC_out, 32'hC);
        bus.MIO_ready = 1'b1;
        tick();
`endif
        check("wait done", 32'(state), 32'd0);
        check("wait mem_w off", 32'(bus.mem_w), 32'd0);
        check("wait pc end", PC_out, 32'hC);
        bus.MIO_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
